// File: rtl/lc4_dmem_arbiter.sv
// Two-port LC4 data-memory arbiter: p0 has priority, p1 may lock for one extra period.
// Define DMEM_ARB_STARVE_EN to add the p1 starvation override after MAX_WAIT lost periods.
module lc4_dmem_arbiter #(
  parameter int WORD_SIZE = 256,
  parameter int ADDR_BITS = 5,
  parameter int MAX_WAIT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gwe,
  input  logic                 p0_req,
  input  logic                 p1_req,
  input  logic                 p0_we,
  input  logic                 p1_we,
  input  logic [ADDR_BITS-1:0] p0_addr,
  input  logic [ADDR_BITS-1:0] p1_addr,
  input  logic [WORD_SIZE-1:0] p0_wdata,
  input  logic [WORD_SIZE-1:0] p1_wdata,
  input  logic                 p1_lock,
  output logic                 p0_gnt,
  output logic                 p1_gnt,
  output logic                 p0_rvalid,
  output logic                 p1_rvalid,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [ADDR_BITS-1:0] o_dmem_raddr,
  output logic [ADDR_BITS-1:0] o_dmem_waddr,
  output logic [WORD_SIZE-1:0] o_dmem_towrite,
  output logic                 o_dmem_we,
  input  logic [WORD_SIZE-1:0] i_dmem_data
);

  typedef enum logic [1:0] {IDLE, G0, G1, G1_LOCK} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] addr_r;
  logic                 we_r;
  logic [WORD_SIZE-1:0] wdata_r;
  logic                 starve;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);
  logic [CW-1:0] wait_cnt;

  assign starve = p1_req && (wait_cnt >= MAX_W);

  // Counts gwe periods p1 spent waiting behind p0; saturates at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (gwe) begin
      if (!p1_req || state_nxt == G1 || state_nxt == G1_LOCK) begin
        wait_cnt <= '0;
      end else if (state_nxt == G0 && wait_cnt < MAX_W) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (gwe) begin
      if (state == G1 && p1_lock) begin
        state_nxt = G1_LOCK;
      end else if (starve) begin
        state_nxt = G1;
      end else if (p0_req) begin
        state_nxt = G0;
      end else if (p1_req) begin
        state_nxt = G1;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_r    <= '0;
      we_r      <= 1'b0;
      wdata_r   <= '0;
      rdata     <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      // rvalid is a single-clk pulse after the gwe edge that closes a read period.
      p0_rvalid <= gwe && (state == G0) && !we_r;
      p1_rvalid <= gwe && (state == G1 || state == G1_LOCK) && !we_r;
      if (gwe) begin
        state <= state_nxt;
        if (state != IDLE && !we_r) begin
          rdata <= i_dmem_data;
        end
        case (state_nxt)
          G0: begin
            addr_r  <= p0_addr;
            we_r    <= p0_we;
            wdata_r <= p0_wdata;
          end
          G1, G1_LOCK: begin
            addr_r  <= p1_addr;
            we_r    <= p1_we;
            wdata_r <= p1_wdata;
          end
          default: begin
            addr_r  <= '0;
            we_r    <= 1'b0;
            wdata_r <= '0;
          end
        endcase
      end
    end
  end

  assign p0_gnt         = (state == G0);
  assign p1_gnt         = (state == G1) || (state == G1_LOCK);
  assign o_dmem_raddr   = addr_r;
  assign o_dmem_waddr   = addr_r;
  assign o_dmem_towrite = wdata_r;
  assign o_dmem_we      = we_r && (state != IDLE);

endmodule

// File: doc/lc4_dmem_arbiter.md
LC4_DMEM_ARBITER -- requirements
Module: lc4_dmem_arbiter

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, default 256, data width; ADDR_BITS, default 5, data-memory address width; MAX_WAIT, default 8, starvation threshold in gwe periods.
REQ-002 Ports SHALL be, one per line, as follows.
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- gwe  in  1  global write enable from lc4_we_gen; the arbiter advances only on clk edges where gwe=1.
- p0_req, p1_req  in  1  port request (p0 = processor, p1 = scrub/host engine).
- p0_we, p1_we  in  1  port write request.
- p0_addr, p1_addr  in  ADDR_BITS  port address.
- p0_wdata, p1_wdata  in  WORD_SIZE  port write data.
- p1_lock  in  1  p1 read-modify-write lock.
- p0_gnt, p1_gnt  out  1  port owns memory this gwe period.
- p0_rvalid, p1_rvalid  out  1  read data valid pulse.
- rdata  out  WORD_SIZE  captured read data (shared).
- o_dmem_raddr, o_dmem_waddr  out  ADDR_BITS  memory addresses.
- o_dmem_towrite  out  WORD_SIZE  memory write data.
- o_dmem_we  out  1  memory write enable.
- i_dmem_data  in  WORD_SIZE  memory read data.

Function
REQ-003 States SHALL be IDLE, G0, G1, G1_LOCK; every state transition SHALL occur only on a clk edge with gwe=1.
REQ-004 From any state at a gwe edge: p0_req=1 SHALL select G0 unless the starvation override (REQ-011) or the lock (REQ-008) applies; otherwise p1_req=1 SHALL select G1; otherwise the next state SHALL be IDLE.
REQ-005 p0_gnt SHALL be 1 exactly in G0, and p1_gnt exactly in G1/G1_LOCK; at most one grant SHALL be high in any cycle.
REQ-006 Requester address, we and wdata SHALL be sampled into registers at the gwe edge that enters a grant state, and held constant for the whole period; o_dmem_raddr = o_dmem_waddr = registered address; o_dmem_we = registered we AND grant state; in IDLE, o_dmem_we SHALL be 0 and addresses/data SHALL be 0.
REQ-007 A granted read SHALL capture i_dmem_data into rdata at the gwe edge that ends the grant period, and assert that port's rvalid for exactly one clk cycle following that edge; writes SHALL produce no rvalid.
REQ-008 If p1_lock=1 at the gwe edge ending G1, the next state SHALL be G1_LOCK regardless of p0_req, sampling p1's new we/addr/wdata; G1_LOCK SHALL always exit per REQ-004 with lock ignored (maximum two consecutive p1 periods).
REQ-009 A request deasserted before a gwe edge SHALL be treated as absent; requests with no gwe edge SHALL not be granted.
REQ-010 rdata SHALL hold its value until the next read capture.

Reset
REQ-011 (see Configuration for starvation override.)
REQ-012 At a clk edge with rst=1, irrespective of gwe: state=IDLE, all grants/rvalid=0, o_dmem_we=0, addresses/towrite/rdata=0, starvation counter=0; a transaction in progress SHALL be discarded without a write or rvalid.

Configuration
REQ-013 Macro DMEM_ARB_STARVE_EN defined: a saturating counter SHALL increment at each gwe edge where p1_req=1 and G0 is selected, clear on any p1 grant or p1_req=0; when counter >= MAX_WAIT, the next gwe edge SHALL select G1 over p0.
REQ-014 Macro undefined: strict p0 priority, no counter logic; p1 can starve indefinitely.

Verification
REQ-015 Reset: rst=1 during a G0 write to addr 3 -> o_dmem_we=0 on the next cycle, memory[3] unchanged, state IDLE.
REQ-016 Priority: p0_req=p1_req=1 at a gwe edge, p0 read addr 2 -> p0_gnt=1, p1_gnt=0; p0_rvalid pulses once with rdata=mem[2].
REQ-017 Lock: p1 read addr 7 with p1_lock=1, then write 0xAA.. to addr 7 while p0_req=1 -> two consecutive p1 periods, p0 granted third; mem[7]=0xAA...
REQ-018 gwe gating: requests held with gwe=0 for 10 cycles -> no grant change, o_dmem_we stays 0.
REQ-019 Starvation (DMEM_ARB_STARVE_EN, MAX_WAIT=8): p0_req, p1_req constantly 1 -> p1 granted on the 9th gwe period; without the macro, p1 is never granted in 50 periods.
REQ-020 Back-to-back: p0 write addr 1 = 0x5 then p0 read addr 1 -> second period rvalid with rdata=0x5.
